xdma_burst_splitter: RTL and testbench
======================================

Name: xdma_burst_splitter

Overview:
- Parametrised successor to the xDMA write-burst reshaper.
- Accepts one write request descriptor (remote address, length in beats, id, type) with a valid/ready handshake.
- Splits the request into AXI-conformant INCR bursts, never crossing a page boundary and never exceeding the AXI length cap.
- Emits one AW descriptor plus one matching W descriptor per burst, then waits for the W path to report completion. Sits between the xDMA request queue and the AW/W channel drivers.

Parameters:
- DataWidth, 512, data bus width in bits; StrbWidth = DataWidth/8 bytes per beat (power of two).
- AddrWidth, 48, remote address width.
- LenWidth, 32, request length width in beats.
- IdWidth, 4, AXI id width.
- PageSize, 4096, boundary in bytes that no burst may cross (power of two, >= StrbWidth).
- MaxBurstBeats, 256, beat cap per burst. Effective cap EffMax = min(MaxBurstBeats, PageSize/StrbWidth).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_id_i  in  IdWidth  request id
- req_addr_i  in  AddrWidth  start address
- req_len_i  in  LenWidth  length in beats
- req_write_data_i  in  1  request carries payload from the ToRemoteData port
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- aw_id_o  out  IdWidth  burst id
- aw_addr_o  out  AddrWidth  burst start address
- aw_len_o  out  8  AXI len (beats-1)
- aw_size_o  out  3  log2(StrbWidth)
- aw_burst_o  out  2  constant 2'b01 (INCR)
- w_num_beats_o  out  9  beats in this burst
- w_is_single_o  out  1  w_num_beats_o == 1
- w_is_write_data_o  out  1  latched req_write_data_i
- burst_valid_o  out  1  AW/W descriptor valid
- burst_ready_i  in  1  descriptor consumed
- w_done_i  in  1  W path finished last burst of the request
- req_done_o  out  1  one-cycle pulse, request complete

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE; req_ready_o=1; burst_valid_o=0; req_done_o=0; all descriptor outputs and internal registers 0. Reset mid-operation drops the in-flight request with no done pulse.
- FSM states: IDLE, BUSY, WAIT_DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i with req_len_i!=0: latch id, address (low log2(StrbWidth) bits forced to 0), length and write_data flag into registers; go to BUSY next cycle.
  - On req_valid_i with req_len_i==0: accept, stay in IDLE, pulse req_done_o the next cycle.
- BUSY:
  - req_ready_o=0; burst_valid_o=1.
  - All outputs are driven from registers only, so they are stable while burst_ready_i=0.
  - Burst size: n = min(rem, EffMax, (PageSize - addr_q mod PageSize)/StrbWidth).
  - aw_len_o = n-1; w_num_beats_o = n.
  - On burst_ready_i: rem_q -= n; addr_q += n*StrbWidth.
  - If n == rem_q, go to WAIT_DONE; burst_valid_o deasserts in the same cycle the state changes.
- WAIT_DONE:
  - req_ready_o=0; burst_valid_o=0.
  - On w_done_i: pulse req_done_o next cycle, return to IDLE.
  - w_done_i seen in any other state is ignored.
- Latency: first descriptor is valid 1 cycle after request acceptance. Back-to-back bursts have no bubble while burst_ready_i=1.
- Arithmetic:
  - Address increment wraps modulo 2^AddrWidth without a flag.
  - The page-remaining computation uses only the low log2(PageSize) address bits.
  - rem_q never underflows, because n <= rem_q by construction.
- No new request is accepted before req_done_o of the previous one (single outstanding request).

Optional Feature:
- Macro XDMA_SPLITTER_STATS_EN.
- Defined:
  - Adds output stat_bursts_o [31:0], the count of burst handshakes since reset, incremented on burst_valid_o & burst_ready_i and saturating at 2^32-1.
  - Adds output stat_split_o [31:0], the count of bursts whose size was limited by the page boundary rather than by rem or EffMax.
  - Both counters clear on rst_i.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
All scenarios use DataWidth=512 and PageSize=4096, so EffMax=64 and aw_size_o=3'b110.
1. addr 0x1000, len 64, burst_ready_i=1 -> one descriptor: addr 0x1000, aw_len 63, num_beats 64; after w_done_i, req_done_o pulses once.
2. addr 0x1000, len 150 -> three descriptors: (0x1000, len 63), (0x2000, len 63), (0x3000, len 21, num_beats 22), issued on consecutive cycles.
3. addr 0x1F80, len 10 -> two descriptors: (0x1F80, num_beats 2), (0x2000, num_beats 8); with stats enabled, stat_split_o=1.
4. addr 0x1000, len 1, burst_ready_i held low for 5 cycles -> burst_valid_o stays 1 and all descriptor fields stay constant; w_is_single_o=1; exactly one handshake occurs.
5. len 0 -> no burst_valid_o; req_done_o=1 exactly one cycle after acceptance; req_ready_o stays 1.
6. rst_i asserted during the second burst of scenario 2 -> next cycle: burst_valid_o=0, req_ready_o=1, no req_done_o; a new request then runs normally.

Source files
------------

// File: rtl/xdma_burst_splitter.sv
// Purpose : splits one xDMA write request into page-safe AXI INCR bursts (AW + W descriptor pairs).
// Latency : first descriptor valid 1 cycle after request accept; back-to-back bursts without bubbles.
// Backpr. : descriptor held stable while burst_ready_i=0; no new request until req_done_o of the last.
//
// Ports:
//   clk_i, rst_i (synchronous, active-high)
//   req_*_i / req_valid_i / req_ready_o : request descriptor in, valid/ready handshake
//   aw_*_o, w_*_o, burst_valid_o / burst_ready_i : one AW/W descriptor pair per burst
//   w_done_i : W path finished the final burst; req_done_o : one-cycle completion pulse
//   stat_bursts_o, stat_split_o : present only when XDMA_SPLITTER_STATS_EN is defined
//
// Optional build macro: XDMA_SPLITTER_STATS_EN adds the burst / page-split statistics counters.

module xdma_burst_splitter #(
    parameter int DataWidth     = 512,
    parameter int AddrWidth     = 48,
    parameter int LenWidth      = 32,
    parameter int IdWidth       = 4,
    parameter int PageSize      = 4096,
    parameter int MaxBurstBeats = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [IdWidth-1:0]   req_id_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 req_write_data_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,

    output logic [IdWidth-1:0]   aw_id_o,
    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [7:0]           aw_len_o,
    output logic [2:0]           aw_size_o,
    output logic [1:0]           aw_burst_o,
    output logic [8:0]           w_num_beats_o,
    output logic                 w_is_single_o,
    output logic                 w_is_write_data_o,
    output logic                 burst_valid_o,
`ifdef XDMA_SPLITTER_STATS_EN
    output logic [31:0]          stat_bursts_o,
    output logic [31:0]          stat_split_o,
`endif
    input  logic                 burst_ready_i,

    input  logic                 w_done_i,
    output logic                 req_done_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int SizeLog   = $clog2(StrbWidth);
    localparam int PageBits  = $clog2(PageSize);
    localparam int PageBeats = PageSize / StrbWidth;
    localparam int EffMax    = (MaxBurstBeats < PageBeats) ? MaxBurstBeats : PageBeats;

    // Page arithmetic is done in PageBits+1 bits so that a full page (offset 0) is representable.
    localparam logic [PageBits:0]    PAGE_BYTES = (PageBits + 1)'(PageSize);
    localparam logic [PageBits:0]    EFF_MAX_P  = (PageBits + 1)'(EffMax);
    localparam logic [AddrWidth-1:0] ADDR_MASK  = ~AddrWidth'(StrbWidth - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IdWidth-1:0]    id_q, id_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [LenWidth-1:0]   rem_q, rem_d;
    logic                  wdat_q, wdat_d;
    logic                  done_q, done_d;

    // ------------------------------------------------------------------
    // Burst sizing, purely from registered state so the descriptor is
    // stable for as long as the consumer stalls.
    // ------------------------------------------------------------------
    logic [PageBits:0] page_left_bytes;
    logic [PageBits:0] page_left_beats;
    logic [PageBits:0] cap_beats;
    logic              page_lim;
    logic              rem_lim;
    logic [8:0]        n_beats;
    logic              split_by_page;
    logic              last_burst;
    logic              busy;
    logic              burst_hs;

    always_comb begin
        // addr_q is beat aligned, so the byte distance to the page end is a whole number of beats.
        page_left_bytes = PAGE_BYTES - {1'b0, addr_q[PageBits-1:0]};
        page_left_beats = page_left_bytes >> SizeLog;
        page_lim        = (page_left_beats < EFF_MAX_P);
        cap_beats       = page_lim ? page_left_beats : EFF_MAX_P;
        rem_lim         = (rem_q < LenWidth'(cap_beats));
        // cap_beats <= EffMax <= 256, and in the rem_lim case rem_q is even smaller, so 9 bits suffice.
        n_beats         = rem_lim ? 9'(rem_q) : 9'(cap_beats);
        // Counted as a page split only when the page end is strictly the tightest limit.
        split_by_page   = page_lim && (rem_q > LenWidth'(cap_beats));
        last_burst      = (rem_q == LenWidth'(n_beats));
    end

    assign busy     = (state_q == BUSY);
    assign burst_hs = busy && burst_ready_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdat_d  = wdat_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_len_i != '0) begin
                        id_d    = req_id_i;
                        addr_d  = req_addr_i & ADDR_MASK;
                        rem_d   = req_len_i;
                        wdat_d  = req_write_data_i;
                        state_d = BUSY;
                    end else begin
                        // Empty request: accepted and completed without touching the bus.
                        done_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (burst_ready_i) begin
                    rem_d  = rem_q - LenWidth'(n_beats);
                    // Wraps silently at the top of the address space.
                    addr_d = addr_q + (AddrWidth'(n_beats) << SizeLog);
                    if (last_burst) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (w_done_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdat_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdat_q  <= wdat_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Variable descriptor fields read as zero outside BUSY so
    // idle/reset values are clean; size and burst type are fixed.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready_o       = (state_q == IDLE);
        burst_valid_o     = busy;
        req_done_o        = done_q;
        aw_size_o         = 3'(SizeLog);
        aw_burst_o        = 2'b01;
        aw_id_o           = '0;
        aw_addr_o         = '0;
        aw_len_o          = '0;
        w_num_beats_o     = '0;
        w_is_single_o     = 1'b0;
        w_is_write_data_o = 1'b0;
        if (busy) begin
            aw_id_o           = id_q;
            aw_addr_o         = addr_q;
            aw_len_o          = 8'(n_beats - 9'd1);
            w_num_beats_o     = n_beats;
            w_is_single_o     = (n_beats == 9'd1);
            w_is_write_data_o = wdat_q;
        end
    end

`ifdef XDMA_SPLITTER_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: saturating counters of burst handshakes and page splits.
    // ------------------------------------------------------------------
    logic [31:0] stat_bursts_q, stat_bursts_d;
    logic [31:0] stat_split_q, stat_split_d;

    always_comb begin
        stat_bursts_d = stat_bursts_q;
        stat_split_d  = stat_split_q;
        if (burst_hs) begin
            if (stat_bursts_q != 32'hFFFF_FFFF) begin
                stat_bursts_d = stat_bursts_q + 32'd1;
            end
            if (split_by_page && (stat_split_q != 32'hFFFF_FFFF)) begin
                stat_split_d = stat_split_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_bursts_q <= '0;
            stat_split_q  <= '0;
        end else begin
            stat_bursts_q <= stat_bursts_d;
            stat_split_q  <= stat_split_d;
        end
    end

    assign stat_bursts_o = stat_bursts_q;
    assign stat_split_o  = stat_split_q;
`else
    // Handshake and split detection only feed the statistics block.
    logic unused_stats;
    assign unused_stats = burst_hs ^ split_by_page;
`endif

endmodule

// File: tb/tb_xdma_burst_splitter.sv
// Directed bench for xdma_burst_splitter (DataWidth 512, PageSize 4096 -> 64 beats max, size 6).
// A monitor logs every AW/W handshake and completion pulse; scenarios compare against hand values.

module tb_xdma_burst_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_id;
    logic [47:0] req_addr;
    logic [31:0] req_len;
    logic        req_wd;
    logic        req_valid;
    logic        req_ready_o;
    logic [3:0]  aw_id_o;
    logic [47:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic [8:0]  w_num_beats_o;
    logic        w_is_single_o;
    logic        w_is_write_data_o;
    logic        burst_valid_o;
    logic        burst_ready;
    logic        w_done;
    logic        req_done_o;
`ifdef XDMA_SPLITTER_STATS_EN
    logic [31:0] stat_bursts_o;
    logic [31:0] stat_split_o;
`endif

    always #5 clk = ~clk;

    xdma_burst_splitter dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_id_i          (req_id),
        .req_addr_i        (req_addr),
        .req_len_i         (req_len),
        .req_write_data_i  (req_wd),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready_o),
        .aw_id_o           (aw_id_o),
        .aw_addr_o         (aw_addr_o),
        .aw_len_o          (aw_len_o),
        .aw_size_o         (aw_size_o),
        .aw_burst_o        (aw_burst_o),
        .w_num_beats_o     (w_num_beats_o),
        .w_is_single_o     (w_is_single_o),
        .w_is_write_data_o (w_is_write_data_o),
        .burst_valid_o     (burst_valid_o),
`ifdef XDMA_SPLITTER_STATS_EN
        .stat_bursts_o     (stat_bursts_o),
        .stat_split_o      (stat_split_o),
`endif
        .burst_ready_i     (burst_ready),
        .w_done_i          (w_done),
        .req_done_o        (req_done_o)
    );

    typedef struct {
        logic [47:0] addr;
        logic [7:0]  len;
        logic [8:0]  beats;
        logic        single;
        logic        wd;
        logic [3:0]  id;
        int          cyc;
    } hs_t;

    hs_t hs_q[$];
    int  cyc      = 0;
    int  done_cnt = 0;
    int  vectors  = 0;
    int  miscompares = 0;

    // Sampled at the clock edge: inputs change 1 time unit after it, so pre-edge values are seen.
    always @(posedge clk) begin
        cyc++;
        if (!rst && burst_valid_o && burst_ready) begin
            hs_q.push_back('{aw_addr_o, aw_len_o, w_num_beats_o, w_is_single_o,
                             w_is_write_data_o, aw_id_o, cyc});
        end
        if (!rst && req_done_o) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] id, input logic [47:0] addr,
                            input logic [31:0] len, input logic wd);
        int n = 0;
        req_id    = id;
        req_addr  = addr;
        req_len   = len;
        req_wd    = wd;
        req_valid = 1'b1;
        while (!req_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("req_accept_timeout", req_ready_o, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_hs(input int cnt);
        int n = 0;
        while (hs_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("hs_timeout", hs_q.size(), cnt);
    endtask

    task automatic finish_req(input string tag);
        int d0 = done_cnt;
        w_done = 1'b1;
        tick();
        w_done = 1'b0;
        chk({tag, "_done_pulse"}, req_done_o, 1);
        chk({tag, "_ready_at_done"}, req_ready_o, 1);
        tick();
        chk({tag, "_done_low"}, req_done_o, 0);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic chk_hs(input string tag, input int idx, input logic [47:0] addr,
                          input logic [8:0] beats);
        if (hs_q.size() > idx) begin
            chk({tag, "_addr"},  hs_q[idx].addr,  addr);
            chk({tag, "_awlen"}, hs_q[idx].len,   8'(beats - 9'd1));
            chk({tag, "_beats"}, hs_q[idx].beats, beats);
        end else begin
            chk({tag, "_present"}, hs_q.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; req_id = '0; req_addr = '0; req_len = '0; req_wd = 1'b0;
        req_valid = 1'b0; burst_ready = 1'b0; w_done = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready",  req_ready_o,   1);
        chk("rst_valid",  burst_valid_o, 0);
        chk("rst_done",   req_done_o,    0);
        chk("rst_addr",   aw_addr_o,     0);
        chk("rst_beats",  w_num_beats_o, 0);
        chk("aw_size",    aw_size_o,     3'b110);
        chk("aw_burst",   aw_burst_o,    2'b01);
        rst = 1'b0;
        tick();

        // 1: single full-size burst
        hs_q.delete();
        burst_ready = 1'b1;
        send_req(4'd1, 48'h1000, 32'd64, 1'b1);
        chk("s1_valid_after_accept", burst_valid_o, 1);
        chk("s1_ready_busy", req_ready_o, 0);
        wait_hs(1);
        chk("s1_valid_wait", burst_valid_o, 0);
        chk("s1_ready_wait", req_ready_o, 0);
        chk("s1_nbursts", hs_q.size(), 1);
        chk_hs("s1_b0", 0, 48'h1000, 9'd64);
        if (hs_q.size() > 0) begin
            chk("s1_id", hs_q[0].id, 4'd1);
            chk("s1_wd", hs_q[0].wd, 1);
            chk("s1_single", hs_q[0].single, 0);
        end
        finish_req("s1");

        // 2: 150 beats over three pages, back to back
        hs_q.delete();
        send_req(4'd2, 48'h1000, 32'd150, 1'b0);
        wait_hs(3);
        chk_hs("s2_b0", 0, 48'h1000, 9'd64);
        chk_hs("s2_b1", 1, 48'h2000, 9'd64);
        chk_hs("s2_b2", 2, 48'h3000, 9'd22);
        if (hs_q.size() == 3) begin
            chk("s2_b1_consecutive", hs_q[1].cyc - hs_q[0].cyc, 1);
            chk("s2_b2_consecutive", hs_q[2].cyc - hs_q[0].cyc, 2);
            chk("s2_wd", hs_q[0].wd, 0);
        end
        d0 = done_cnt;
        repeat (3) tick();
        chk("s2_no_early_done", done_cnt - d0, 0);
        chk("s2_valid_wait", burst_valid_o, 0);
        finish_req("s2");

        // 3: crossing a page boundary splits 2 + 8
        hs_q.delete();
        send_req(4'd3, 48'h1F80, 32'd10, 1'b1);
        wait_hs(2);
        chk("s3_nbursts", hs_q.size(), 2);
        chk_hs("s3_b0", 0, 48'h1F80, 9'd2);
        chk_hs("s3_b1", 1, 48'h2000, 9'd8);
`ifdef XDMA_SPLITTER_STATS_EN
        chk("s3_stat_split",  stat_split_o,  1);
        chk("s3_stat_bursts", stat_bursts_o, 6);
`endif
        finish_req("s3");

        // w_done outside WAIT_DONE is ignored
        d0 = done_cnt;
        w_done = 1'b1;
        tick();
        w_done = 1'b0;
        tick();
        chk("idle_wdone_ignored", done_cnt - d0, 0);

        // 4: single beat held under backpressure
        hs_q.delete();
        burst_ready = 1'b0;
        send_req(4'd5, 48'h1000, 32'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("s4_valid_held",  burst_valid_o, 1);
            chk("s4_addr_held",   aw_addr_o,     48'h1000);
            chk("s4_len_held",    aw_len_o,      0);
            chk("s4_single_held", w_is_single_o, 1);
            chk("s4_id_held",     aw_id_o,       4'd5);
            tick();
        end
        burst_ready = 1'b1;
        tick();
        chk("s4_valid_after_hs", burst_valid_o, 0);
        chk("s4_nbursts", hs_q.size(), 1);
        chk_hs("s4_b0", 0, 48'h1000, 9'd1);
        finish_req("s4");

        // 5: zero-length request
        hs_q.delete();
        d0 = done_cnt;
        send_req(4'd6, 48'h0, 32'd0, 1'b0);
        chk("s5_done_pulse", req_done_o, 1);
        chk("s5_ready",      req_ready_o, 1);
        chk("s5_no_valid",   burst_valid_o, 0);
        tick();
        chk("s5_done_low",   req_done_o, 0);
        chk("s5_ready_kept", req_ready_o, 1);
        chk("s5_no_bursts",  hs_q.size(), 0);
        chk("s5_done_count", done_cnt - d0, 1);

        // 6: reset during the second burst, then a fresh request
        hs_q.delete();
        send_req(4'd7, 48'h1000, 32'd150, 1'b0);
        tick();
        chk("s6_second_valid", burst_valid_o, 1);
        chk("s6_second_addr",  aw_addr_o, 48'h2000);
        burst_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_rst_valid", burst_valid_o, 0);
        chk("s6_rst_ready", req_ready_o, 1);
        chk("s6_rst_done",  req_done_o, 0);
        chk("s6_rst_addr",  aw_addr_o, 0);
        d0 = done_cnt;
        repeat (3) tick();
        chk("s6_no_done_after_rst", done_cnt - d0, 0);
        hs_q.delete();
        burst_ready = 1'b1;
        send_req(4'd8, 48'h5047, 32'd3, 1'b1);
        wait_hs(1);
        chk_hs("s6_new", 0, 48'h5040, 9'd3);
        if (hs_q.size() > 0) chk("s6_new_id", hs_q[0].id, 4'd8);
`ifdef XDMA_SPLITTER_STATS_EN
        chk("s6_stat_bursts", stat_bursts_o, 1);
        chk("s6_stat_split",  stat_split_o,  0);
`endif
        finish_req("s6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
